fofb_readout_sequencer: RTL and testbench
=========================================

# fofb_readout_sequencer

Sequences the fast-orbit-feedback DSP readout of the merged BPM readout DPRAMs once per FA cycle. It arms on each FA strobe, waits for the link-reader's readout-valid or readout-timeout flag, then sweeps the readout address from 0 to bpmCount-1 under DSP back-pressure. It issues one flush step so the final entry is committed to the saved-value and MicroBlaze DPRAMs, and reports overruns and timing to the MicroBlaze. It sits in the sysClk domain between the link-reader block and the FOFB correction DSP.

## Interface
- FOFB_INDEX_WIDTH, 9: readout address width; the maximum sweep length is 2^FOFB_INDEX_WIDTH.
- sysClk  in  1  system clock; the only clock.
- sysReset  in  1  reset, synchronous and active-high.
- FAstrobe  in  1  one-cycle FA cycle strobe.
- readoutValid  in  1  level from the link reader; all cells have been received for this FA cycle.
- readTimeout  in  1  level from the link reader; the readout window expired without all cells.
- enable  in  1  sweeps are permitted; 0 forces IDLE at the next cycle.
- bpmCount  in  FOFB_INDEX_WIDTH+1  number of entries to sweep; sampled on entry to SWEEP.
- dspReady  in  1  the DSP accepts the currently presented address.
- fofbDSPreadoutAddress  out  FOFB_INDEX_WIDTH  readout address to the link reader.
- dspStrobe  out  1  readout data for the accepted address is valid this cycle.
- dspFirst, dspLast  out  1  qualify dspStrobe for the first and last entries.
- dspStale  out  1  the current sweep was triggered by a timeout; held for the whole sweep.
- sweepActive  out  1  the state is SWEEP or FLUSH.
- sweepDone  out  1  one-cycle pulse when FLUSH completes.
- status  out  32  {overrunCount[7:0], lastSweepCycles[15:0], sweepCount[7:0]}.

## Operation
- States and transitions:
  - IDLE: on FAstrobe with enable=1, go to ARMED.
  - ARMED: on readoutValid=1, go to SWEEP with dspStale=0. Otherwise, on readTimeout=1, go to SWEEP with dspStale=1. readoutValid has priority when both are high.
  - SWEEP: present addresses 0..N-1. The address increments only in a cycle where dspReady=1. After address N-1 is accepted, go to FLUSH.
  - FLUSH: present address N mod 2^FOFB_INDEX_WIDTH for exactly one cycle, ignoring dspReady. This bit-0 change commits entry N-1 downstream. Then pulse sweepDone and go to IDLE.
- N = min(bpmCount, 2^FOFB_INDEX_WIDTH).
- N=0: go ARMED→SWEEP→FLUSH→IDLE with no dspStrobe. FLUSH presents address 0 and sweepDone still pulses.
- Parking: after FLUSH, the address holds N mod 2^W until the next sweep. The next sweep starts at 0. If N is odd, downstream performs a spurious write of entry N; that entry lies outside the active range and this is accepted.
- An FAstrobe in ARMED, SWEEP or FLUSH is an overrun:
  - overrunCount increments and saturates at 255.
  - The sweep is abandoned without a flush, and the state goes to ARMED with dspStale cleared.
  - The address parks at its current value.
- sweepCount increments, with wrap, on every sweepDone.
- lastSweepCycles counts sysClk cycles from entry to SWEEP through FLUSH inclusive, saturates at 0xFFFF, and is latched at sweepDone.
- Deasserting enable mid-sweep goes to IDLE next cycle with no flush and no sweepDone.

## Timing
- Reset values:
  - state IDLE.
  - fofbDSPreadoutAddress 0.
  - dspStrobe, dspFirst, dspLast, dspStale, sweepActive and sweepDone all 0.
  - status 0.
- Downstream readout latency is 1 cycle. When address A is presented with dspReady=1 in cycle t, dspStrobe is 1 in cycle t+1.
  - dspFirst is 1 at t+1 when A=0.
  - dspLast is 1 at t+1 when A=N-1.
- A stall (dspReady=0) holds the address and produces no strobe in the following cycle. Each address is strobed exactly once.
- The trigger is registered: the first address is presented the cycle after readoutValid/readTimeout is seen in ARMED.
- sweepActive is registered with the state.
- Minimum sweep with no stalls: N+1 cycles. The first address appears 1 cycle after the trigger.
- sweepDone asserts in the cycle after the FLUSH cycle.
- Reset asserted mid-sweep returns all outputs to their reset values at the next edge. No flush is issued.

## Test plan
- bpmCount=4, dspReady=1, readoutValid 10 cycles after FAstrobe:
  - Addresses are 0,1,2,3 then 4.
  - 4 strobes occur, with dspFirst on the first and dspLast on the fourth.
  - sweepDone pulses; lastSweepCycles=5 and sweepCount=1.
- bpmCount=3, dspReady toggling 1,0,1,0,...: exactly 3 strobes. The address holds during every low cycle. Flush address is 3.
- readTimeout without readoutValid, bpmCount=2: dspStale=1 for the whole sweep. Both strobes occur; the next sweep triggered by readoutValid shows dspStale=0.
- A second FAstrobe while address=5 of a 16-entry sweep:
  - overrunCount=1 and the sweep is abandoned with no sweepDone.
  - A later readoutValid restarts the sweep at address 0.
- bpmCount=0 gives no strobe and one sweepDone. bpmCount=2^W+5 gives 2^W strobes and a flush address of 0.
- sysReset asserted during SWEEP: all outputs return to their reset values the next cycle, and 300 overrun events leave overrunCount at 255.

Source files
------------

// File: rtl/fofb_readout_sequencer.sv
// ==================================================================
// fofb_readout_sequencer: per-FA-cycle FOFB DSP readout sweep sequencer
// Revision 1.0
// ==================================================================
`default_nettype none

module fofb_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH = 9
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        FAstrobe,
  input  logic                        readoutValid,
  input  logic                        readTimeout,
  input  logic                        enable,
  input  logic [FOFB_INDEX_WIDTH:0]   bpmCount,
  input  logic                        dspReady,
  output logic [FOFB_INDEX_WIDTH-1:0] fofbDSPreadoutAddress,
  output logic                        dspStrobe,
  output logic                        dspFirst,
  output logic                        dspLast,
  output logic                        dspStale,
  output logic                        sweepActive,
  output logic                        sweepDone,
  output logic [31:0]                 status
);

  localparam logic [FOFB_INDEX_WIDTH:0] c_max_count = {1'b1, {FOFB_INDEX_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SWEEP = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [FOFB_INDEX_WIDTH:0]     r_count;
  logic [FOFB_INDEX_WIDTH:0]     w_clamped;
  logic [15:0]                   r_cycles;
  logic [15:0]                   r_last_cycles;
  logic [7:0]                    r_overruns;
  logic [7:0]                    r_sweeps;
  logic                          w_overrun;
  logic                          w_start;
  logic                          w_empty;
  logic                          w_accept;
  logic                          w_final;
  logic                          w_done;
  logic                          w_next_active;

  assign w_clamped = (bpmCount > c_max_count) ? c_max_count : bpmCount;
  assign w_empty   = (r_count == '0);
  assign w_overrun = FAstrobe && (r_state != S_IDLE);
  assign w_start   = (r_state == S_ARMED) && enable && !FAstrobe
                     && (readoutValid || readTimeout);
  assign w_accept  = (r_state == S_SWEEP) && enable && !FAstrobe && !w_empty && dspReady;
  assign w_final   = w_accept && ({1'b0, fofbDSPreadoutAddress} == (r_count - 1'b1));
  assign w_done    = (r_state == S_FLUSH) && enable && !FAstrobe;
  assign w_next_active = (w_next == S_SWEEP) || (w_next == S_FLUSH);

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Overrun beats normal progress; a dropped enable beats everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (FAstrobe && enable) w_next = S_ARMED;
      S_ARMED: if (w_start) w_next = S_SWEEP;
      S_SWEEP: if (w_empty || w_final) w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_overrun) w_next = S_ARMED;
    if (!enable)   w_next = S_IDLE;
  end

  // Incrementing past N-1 naturally lands on the flush address N mod 2^W.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      fofbDSPreadoutAddress <= '0;
      r_count               <= '0;
    end else if (w_start) begin
      fofbDSPreadoutAddress <= '0;
      r_count               <= w_clamped;
    end else if (w_accept) begin
      fofbDSPreadoutAddress <= fofbDSPreadoutAddress + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      dspStrobe   <= 1'b0;
      dspFirst    <= 1'b0;
      dspLast     <= 1'b0;
      dspStale    <= 1'b0;
      sweepActive <= 1'b0;
      sweepDone   <= 1'b0;
    end else begin
      dspStrobe   <= w_accept;
      dspFirst    <= w_accept && (fofbDSPreadoutAddress == '0);
      dspLast     <= w_final;
      sweepActive <= w_next_active;
      sweepDone   <= w_done;
      if (w_start) begin
        dspStale <= !readoutValid;
      end else if (!w_next_active) begin
        dspStale <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      r_cycles      <= '0;
      r_last_cycles <= '0;
      r_overruns    <= '0;
      r_sweeps      <= '0;
    end else begin
      if (w_start) begin
        r_cycles <= 16'd1;
      end else if (((r_state == S_SWEEP) || (r_state == S_FLUSH)) && (r_cycles != 16'hFFFF)) begin
        r_cycles <= r_cycles + 16'd1;
      end
      if (w_done) begin
        r_last_cycles <= r_cycles;
        r_sweeps      <= r_sweeps + 8'd1;
      end
      if (w_overrun && (r_overruns != 8'hFF)) begin
        r_overruns <= r_overruns + 8'd1;
      end
    end
  end

  assign status = {r_overruns, r_last_cycles, r_sweeps};

endmodule

`default_nettype wire

// File: tb/tb_fofb_readout_sequencer.sv
// ==================================================================
// tb_fofb_readout_sequencer: randomized sweep bench with a per-sweep reference model
// Revision 1.0
// ==================================================================
`default_nettype none

module tb_fofb_readout_sequencer;

  localparam int W    = 9;
  localparam int MAXN = 1 << W;

  logic          sysClk = 1'b0;
  logic          sysReset;
  logic          FAstrobe;
  logic          readoutValid;
  logic          readTimeout;
  logic          enable;
  logic [W:0]    bpmCount;
  logic          dspReady;
  logic [W-1:0]  addr;
  logic          dspStrobe;
  logic          dspFirst;
  logic          dspLast;
  logic          dspStale;
  logic          sweepActive;
  logic          sweepDone;
  logic [31:0]   status;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    e_sweeps = '0;
  logic [7:0]    e_ovr    = '0;
  logic [15:0]   e_last   = '0;

  fofb_readout_sequencer #(.FOFB_INDEX_WIDTH(W)) dut (
    .sysClk               (sysClk),
    .sysReset             (sysReset),
    .FAstrobe             (FAstrobe),
    .readoutValid         (readoutValid),
    .readTimeout          (readTimeout),
    .enable               (enable),
    .bpmCount             (bpmCount),
    .dspReady             (dspReady),
    .fofbDSPreadoutAddress(addr),
    .dspStrobe            (dspStrobe),
    .dspFirst             (dspFirst),
    .dspLast              (dspLast),
    .dspStale             (dspStale),
    .sweepActive          (sweepActive),
    .sweepDone            (sweepDone),
    .status               (status)
  );

  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check(tag, status, {e_ovr, e_last, e_sweeps});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_strobe"}, dspStrobe, 0);
    check({tag, "_first"}, dspFirst, 0);
    check({tag, "_last"}, dspLast, 0);
    check({tag, "_stale"}, dspStale, 0);
    check({tag, "_active"}, sweepActive, 0);
    check({tag, "_done"}, sweepDone, 0);
    check({tag, "_status"}, status, 0);
  endtask

  task automatic check_strobe(input string tag, input bit acc, input int idx, input int n);
    check({tag, "_strobe"}, dspStrobe, acc);
    check({tag, "_first"}, dspFirst, acc && (idx == 0));
    check({tag, "_last"}, dspLast, acc && (idx == n - 1));
  endtask

  function automatic bit pick_ready(input int mode, input int i);
    if (i > 3000) return 1'b1;
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2) == 0;
      default: return ($urandom % 3) != 0;
    endcase
  endfunction

  // kind: 0 readoutValid, 1 readTimeout, 2 both together
  task automatic trigger(input bit do_fa, input int delay, input int kind, input int n_bpm);
    readoutValid = 1'b0;
    readTimeout  = 1'b0;
    if (do_fa) begin
      FAstrobe = 1'b1;
      step();
      FAstrobe = 1'b0;
    end
    for (int d = 0; d < delay; d++) begin
      check("armed_active", sweepActive, 0);
      check("armed_strobe", dspStrobe, 0);
      dspReady = 1'($urandom);
      step();
    end
    bpmCount     = (W+1)'(n_bpm);
    readoutValid = (kind != 1);
    readTimeout  = (kind != 0);
    step();
    readoutValid = 1'b0;
    readTimeout  = 1'b0;
    bpmCount     = (W+1)'($urandom);
  endtask

  task automatic do_abort(input int kind, input int park);
    dspReady = 1'($urandom);
    case (kind)
      1: begin
        FAstrobe = 1'b1;
        step();
        FAstrobe = 1'b0;
        e_ovr = (e_ovr == 8'hFF) ? 8'hFF : e_ovr + 8'd1;
      end
      2: begin
        enable = 1'b0;
        step();
        enable = 1'b1;
      end
      default: begin
        sysReset = 1'b1;
        step();
        sysReset = 1'b0;
        e_ovr    = '0;
        e_last   = '0;
        e_sweeps = '0;
      end
    endcase
    if (kind == 3) begin
      check_reset_values("rst_mid");
    end else begin
      check("abort_active", sweepActive, 0);
      check("abort_strobe", dspStrobe, 0);
      check("abort_done", sweepDone, 0);
      check("abort_stale", dspStale, 0);
      check("abort_park", addr, park);
      check_status("abort_status");
    end
  endtask

  // Called in the first SWEEP cycle; models addresses, strobes, flush and status.
  task automatic run_sweep(input int n_bpm, input bit exp_stale, input int mode,
                           input int abort_kind, input int abort_at);
    int n;
    int k;
    int i;
    int prev_idx;
    bit prev_acc;
    bit r;
    n = (n_bpm > MAXN) ? MAXN : n_bpm;
    k = 0;
    i = 0;
    prev_idx = 0;
    prev_acc = 1'b0;
    while ((n == 0 && i == 0) || (n > 0 && k < n)) begin
      check("sw_addr", addr, k);
      check("sw_active", sweepActive, 1);
      check("sw_stale", dspStale, exp_stale);
      check("sw_done", sweepDone, 0);
      check_strobe("sw", prev_acc, prev_idx, n);
      if (abort_kind != 0 && k == abort_at) begin
        do_abort(abort_kind, k);
        return;
      end
      r = pick_ready(mode, i);
      dspReady = r;
      if (n > 0 && r) begin
        prev_acc = 1'b1;
        prev_idx = k;
        k++;
      end else begin
        prev_acc = 1'b0;
      end
      step();
      i++;
    end
    check("flush_addr", addr, n % MAXN);
    check("flush_active", sweepActive, 1);
    check("flush_stale", dspStale, exp_stale);
    check_strobe("flush", prev_acc, prev_idx, n);
    dspReady = 1'($urandom);
    step();
    i++;
    e_sweeps = e_sweeps + 8'd1;
    e_last   = (i > 65535) ? 16'hFFFF : 16'(i);
    check("done_pulse", sweepDone, 1);
    check("done_active", sweepActive, 0);
    check("done_strobe", dspStrobe, 0);
    check("done_stale", dspStale, 0);
    check("done_park", addr, n % MAXN);
    check_status("done_status");
    step();
    check("done_once", sweepDone, 0);
  endtask

  initial begin
    int n;
    int kind;
    sysReset     = 1'b1;
    FAstrobe     = 1'b0;
    readoutValid = 1'b0;
    readTimeout  = 1'b0;
    enable       = 1'b1;
    bpmCount     = '0;
    dspReady     = 1'b0;
    step();
    step();
    check_reset_values("reset");
    sysReset = 1'b0;

    trigger(1'b1, 10, 0, 4);
    run_sweep(4, 1'b0, 0, 0, 0);
    check("tp1_cycles", status[23:8], 5);
    check("tp1_sweeps", status[7:0], 1);

    trigger(1'b1, 3, 0, 3);
    run_sweep(3, 1'b0, 1, 0, 0);
    check("tp2_cycles", status[23:8], 6);

    trigger(1'b1, 2, 1, 2);
    run_sweep(2, 1'b1, 0, 0, 0);
    trigger(1'b1, 2, 0, 2);
    run_sweep(2, 1'b0, 2, 0, 0);

    trigger(1'b1, 1, 0, 16);
    run_sweep(16, 1'b0, 0, 1, 5);
    check("tp4_overrun", status[31:24], 1);
    trigger(1'b0, 2, 0, 16);
    run_sweep(16, 1'b0, 2, 0, 0);

    trigger(1'b1, 0, 0, 0);
    run_sweep(0, 1'b0, 2, 0, 0);
    trigger(1'b1, 1, 0, MAXN + 5);
    run_sweep(MAXN + 5, 1'b0, 0, 0, 0);
    check("tp5_flush_wrap", addr, 0);

    trigger(1'b1, 1, 1, 8);
    run_sweep(8, 1'b1, 2, 2, 3);

    for (int s = 0; s < 20; s++) begin
      n    = (($urandom % 4) == 0) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 20));
      kind = int'($urandom_range(0, 2));
      trigger(1'b1, int'($urandom % 5), kind, n);
      run_sweep(n, kind == 1, int'($urandom % 3), 0, 0);
    end

    trigger(1'b1, 1, 0, 10);
    run_sweep(10, 1'b0, 0, 3, 4);

    FAstrobe = 1'b1;
    step();
    for (int o = 0; o < 300; o++) begin
      step();
      e_ovr = (e_ovr == 8'hFF) ? 8'hFF : e_ovr + 8'd1;
    end
    FAstrobe = 1'b0;
    check("ovr_saturate", status[31:24], 255);
    check_status("ovr_status");
    trigger(1'b0, 1, 0, 5);
    run_sweep(5, 1'b0, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
